// File: rtl/ldpc_dec_ctrl.sv
// LDPC decoder frame controller.
// Accepts one frame of channel LLRs, resets and enables the decoder core,
// watches the core status (or a cycle timeout) and hands the decoded word
// to the sink with a valid/ready handshake. Keeps saturating frame and
// failure counters.
module ldpc_dec_ctrl #(
    parameter int R       = 24,
    parameter int D       = 24,
    parameter int data_w  = 8,
    parameter int MAX_CYC = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [R*D*data_w-1:0]    in_llr,
    output logic                     core_en,
    output logic                     core_rst,
    output logic [R*D*data_w-1:0]    core_l,
    input  logic [R*D-1:0]           core_s,
    input  logic [1:0]               core_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [R*D-1:0]           out_bits,
    output logic                     out_ok,
    output logic                     out_tmo,
    output logic                     busy,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              fail_cnt
);

    localparam int LW = R * D * data_w;
    localparam int NW = R * D;
    localparam logic [9:0] MAX_C = 10'(MAX_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_q,     state_d;
    logic            load_cnt_q,  load_cnt_d;
    logic [9:0]      cyc_q,       cyc_d;
    logic            in_ready_q,  in_ready_d;
    logic            core_en_q,   core_en_d;
    logic            core_rst_q,  core_rst_d;
    logic [LW-1:0]   core_l_q,    core_l_d;
    logic            out_valid_q, out_valid_d;
    logic [NW-1:0]   out_bits_q,  out_bits_d;
    logic            out_ok_q,    out_ok_d;
    logic            out_tmo_q,   out_tmo_d;
    logic            busy_q,      busy_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [15:0]     fail_cnt_q,  fail_cnt_d;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state and next-output computation; every output is derived from
    // the next state so that it is registered alongside it.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        cyc_d       = cyc_q;
        core_l_d    = core_l_q;
        out_bits_d  = out_bits_q;
        out_ok_d    = out_ok_q;
        out_tmo_d   = out_tmo_q;
        frame_cnt_d = frame_cnt_q;
        fail_cnt_d  = fail_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    core_l_d   = in_llr;
                    load_cnt_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Two LOAD cycles with the core held in reset.
                if (load_cnt_q) begin
                    cyc_d   = 10'd0;
                    state_d = ST_RUN;
                end else begin
                    load_cnt_d = 1'b1;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q + 10'd1;
                // Cycle 0 of RUN is a guard cycle: the core status is still
                // reflecting its reset and is not trusted.
                if (cyc_q != 10'd0 && core_status[0]) begin
                    out_bits_d = core_s;
                    out_ok_d   = 1'b1;
                    out_tmo_d  = 1'b0;
                    state_d    = ST_DONE;
                end else if (cyc_q != 10'd0 && core_status[1]) begin
                    out_bits_d = core_s;
                    out_ok_d   = 1'b0;
                    out_tmo_d  = 1'b0;
                    state_d    = ST_DONE;
                end else if (cyc_q == MAX_C) begin
                    out_bits_d = core_s;
                    out_ok_d   = 1'b0;
                    out_tmo_d  = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    frame_cnt_d = sat_inc(frame_cnt_q);
                    if (!out_ok_q) begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        core_rst_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        core_en_d   = (state_d == ST_RUN);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= 1'b0;
            cyc_q       <= 10'd0;
            in_ready_q  <= 1'b0;
            core_en_q   <= 1'b0;
            core_rst_q  <= 1'b1;
            core_l_q    <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_ok_q    <= 1'b0;
            out_tmo_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            fail_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            cyc_q       <= cyc_d;
            in_ready_q  <= in_ready_d;
            core_en_q   <= core_en_d;
            core_rst_q  <= core_rst_d;
            core_l_q    <= core_l_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_ok_q    <= out_ok_d;
            out_tmo_q   <= out_tmo_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign core_en   = core_en_q;
    assign core_rst  = core_rst_q;
    assign core_l    = core_l_q;
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_ok    = out_ok_q;
    assign out_tmo   = out_tmo_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// Testbench for ldpc_dec_ctrl: directed and random frames checked against a
// per-frame reference model (completion cycle and outcome derived from the
// status schedule), plus reset behaviour.
module tb_ldpc_dec_ctrl;

    localparam int R    = 4;
    localparam int D    = 6;
    localparam int DW   = 8;
    localparam int MAXC = 200;
    localparam int LW   = R * D * DW;
    localparam int NW   = R * D;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [LW-1:0]   in_llr;
    logic            core_en;
    logic            core_rst;
    logic [LW-1:0]   core_l;
    logic [NW-1:0]   core_s;
    logic [1:0]      core_status;
    logic            out_valid;
    logic            out_ready;
    logic [NW-1:0]   out_bits;
    logic            out_ok;
    logic            out_tmo;
    logic            busy;
    logic [15:0]     frame_cnt;
    logic [15:0]     fail_cnt;

    ldpc_dec_ctrl #(
        .R       (R),
        .D       (D),
        .data_w  (DW),
        .MAX_CYC (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_llr      (in_llr),
        .core_en     (core_en),
        .core_rst    (core_rst),
        .core_l      (core_l),
        .core_s      (core_s),
        .core_status (core_status),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bits    (out_bits),
        .out_ok      (out_ok),
        .out_tmo     (out_tmo),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .fail_cnt    (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_frames = 0;
    int exp_fails  = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_llr();
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < LW; i += 32) v = (v << 32) | LW'($urandom);
        return v;
    endfunction

    function automatic logic [NW-1:0] rand_bits();
        return NW'($urandom);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, ".frame_cnt"}, frame_cnt, exp_frames);
        check_val({tag, ".fail_cnt"}, fail_cnt, exp_fails);
    endtask

    // One complete frame. stat_idx selects the RUN cycle (1..MAXC) at which
    // stat_code is presented; any other value means no status at all.
    task automatic do_frame(input string tag, input int stat_idx, input logic [1:0] stat_code,
                            input bit guard_hit, input int idle_wait, input int hold);
        logic [1:0]    plan [0:MAXC];
        logic [LW-1:0] llr;
        logic [NW-1:0] s_now;
        logic [NW-1:0] s_end;
        int            e;
        bit            exp_ok;
        bit            exp_tmo;

        for (int j = 0; j <= MAXC; j++) plan[j] = 2'b00;
        if (guard_hit) plan[0] = 2'b01;
        if (stat_idx >= 1 && stat_idx <= MAXC) plan[stat_idx] = stat_code;

        // Reference: first non-guard RUN cycle showing any status ends the
        // frame (converged wins); otherwise the timeout at MAXC does.
        e = MAXC;
        for (int j = MAXC; j >= 1; j--) if (plan[j] != 2'b00) e = j;
        if (plan[e] != 2'b00) begin
            exp_ok  = plan[e][0];
            exp_tmo = 1'b0;
        end else begin
            exp_ok  = 1'b0;
            exp_tmo = 1'b1;
        end
        s_end = '0;

        in_valid = 1'b0;
        for (int w = 0; w < idle_wait; w++) begin
            check_val({tag, ".idle_ready"}, in_ready, 1'b1);
            check_val({tag, ".idle_core_rst"}, core_rst, 1'b1);
            check_val({tag, ".idle_busy"}, busy, 1'b0);
            in_llr = rand_llr();
            step();
        end

        // Cycle 0: handshake.
        check_val({tag, ".accept_ready"}, in_ready, 1'b1);
        check_val({tag, ".accept_core_en"}, core_en, 1'b0);
        llr      = rand_llr();
        in_llr   = llr;
        in_valid = 1'b1;
        step();

        // Cycles 1-2: core held in reset.
        for (int k = 1; k <= 2; k++) begin
            check_val({tag, ".load_core_rst"}, core_rst, 1'b1);
            check_val({tag, ".load_core_en"}, core_en, 1'b0);
            check_val({tag, ".load_ready"}, in_ready, 1'b0);
            check_val({tag, ".load_busy"}, busy, 1'b1);
            check_val({tag, ".load_core_l"}, core_l, llr);
            in_valid = 1'($urandom);
            in_llr   = rand_llr();
            step();
        end

        // RUN from cycle 3.
        for (int j = 0; j <= e; j++) begin
            check_val({tag, ".run_core_en"}, core_en, 1'b1);
            check_val({tag, ".run_core_rst"}, core_rst, 1'b0);
            check_val({tag, ".run_out_valid"}, out_valid, 1'b0);
            check_val({tag, ".run_ready"}, in_ready, 1'b0);
            check_val({tag, ".run_core_l"}, core_l, llr);
            core_status = plan[j];
            s_now       = rand_bits();
            core_s      = s_now;
            if (j == e) s_end = s_now;
            in_valid = 1'($urandom);
            in_llr   = rand_llr();
            step();
        end
        core_status = 2'b00;

        // DONE: result held until released.
        for (int h = 0; h <= hold; h++) begin
            check_val({tag, ".done_valid"}, out_valid, 1'b1);
            check_val({tag, ".done_ok"}, out_ok, exp_ok);
            check_val({tag, ".done_tmo"}, out_tmo, exp_tmo);
            check_val({tag, ".done_bits"}, out_bits, s_end);
            check_val({tag, ".done_ready"}, in_ready, 1'b0);
            check_val({tag, ".done_core_en"}, core_en, 1'b0);
            check_val({tag, ".done_core_l"}, core_l, llr);
            check_counters({tag, ".done"});
            core_s    = rand_bits();
            out_ready = (h == hold);
            in_valid  = (h == hold) ? 1'b0 : 1'($urandom);
            step();
        end
        out_ready = 1'b0;

        exp_frames = (exp_frames < 65535) ? exp_frames + 1 : 65535;
        if (!exp_ok) exp_fails = (exp_fails < 65535) ? exp_fails + 1 : 65535;

        check_val({tag, ".after_valid"}, out_valid, 1'b0);
        check_val({tag, ".after_ready"}, in_ready, 1'b1);
        check_val({tag, ".after_core_rst"}, core_rst, 1'b1);
        check_val({tag, ".after_busy"}, busy, 1'b0);
        check_counters({tag, ".after"});
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, ".ready"}, in_ready, 1'b0);
        check_val({tag, ".core_rst"}, core_rst, 1'b1);
        check_val({tag, ".core_en"}, core_en, 1'b0);
        check_val({tag, ".out_valid"}, out_valid, 1'b0);
        check_val({tag, ".out_ok"}, out_ok, 1'b0);
        check_val({tag, ".out_tmo"}, out_tmo, 1'b0);
        check_val({tag, ".busy"}, busy, 1'b0);
        check_val({tag, ".out_bits"}, out_bits, '0);
        check_val({tag, ".core_l"}, core_l, '0);
        check_counters(tag);
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_llr      = '0;
        core_s      = '0;
        core_status = 2'b00;
        out_ready   = 1'b0;

        // Power-on reset.
        step();
        step();
        check_reset_values("por");
        rst = 1'b1;
        step();
        check_val("por.ready_after_release", in_ready, 1'b1);
        check_val("por.core_rst_after_release", core_rst, 1'b1);

        // Directed frames.
        do_frame("conv40",    40,   2'b01, 1'b0, 2, 1);
        do_frame("timeout",   0,    2'b00, 1'b0, 1, 1);
        do_frame("both11",    17,   2'b11, 1'b0, 0, 3);
        do_frame("hold20",    25,   2'b10, 1'b0, 1, 20);
        do_frame("guard",     30,   2'b01, 1'b1, 0, 1);
        do_frame("first",     1,    2'b01, 1'b0, 0, 0);
        do_frame("edge_fail", MAXC, 2'b10, 1'b0, 0, 0);
        do_frame("edge_conv", MAXC, 2'b01, 1'b1, 0, 2);

        // Random frames; stat_idx above MAXC leaves only the timeout.
        for (int n = 0; n < 20; n++) begin
            do_frame("rand", $urandom_range(1, 260), 2'($urandom_range(1, 3)),
                     1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
        end

        // Reset in the middle of RUN.
        in_valid = 1'b0;
        check_val("mid.accept_ready", in_ready, 1'b1);
        in_llr   = rand_llr();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++) step();
        check_val("mid.core_en_before", core_en, 1'b1);
        rst = 1'b0;
        #1;
        exp_frames = 0;
        exp_fails  = 0;
        check_reset_values("mid");
        step();
        step();
        check_reset_values("mid_hold");
        rst = 1'b1;
        check_val("mid.ready_before_edge", in_ready, 1'b0);
        step();
        check_val("mid.ready_after_release", in_ready, 1'b1);
        check_val("mid.core_rst_after_release", core_rst, 1'b1);
        check_val("mid.valid_after_release", out_valid, 1'b0);
        check_counters("mid.after_release");

        do_frame("post_reset", 9, 2'b01, 1'b0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldpc_dec_ctrl.md
LDPC_DEC_CTRL -- requirements
Module: ldpc_dec_ctrl

Interface
REQ-001 SHALL have parameter R, default 24: block rows of the base matrix.
REQ-002 SHALL have parameter D, default 24: expansion factor.
REQ-003 SHALL have parameter data_w, default 8: LLR width, two's complement.
REQ-004 SHALL have parameter MAX_CYC, default 1023: RUN-cycle timeout limit, range 4..1023.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: frame LLRs present.
REQ-008 SHALL have port in_ready, output, 1 bit: controller accepts a frame.
REQ-009 SHALL have port in_llr, input, R*D*data_w bits: channel LLRs.
REQ-010 SHALL have port core_en, output, 1 bit: decoder core enable.
REQ-011 SHALL have port core_rst, output, 1 bit: decoder core reset, active-high.
REQ-012 SHALL have port core_l, output, R*D*data_w bits: registered LLRs driven to the core.
REQ-013 SHALL have port core_s, input, R*D bits: core hard decisions.
REQ-014 SHALL have port core_status, input, 2 bits: bit0 = converged, bit1 = iteration limit failure.
REQ-015 SHALL have port out_valid, input/output direction output, 1 bit: result valid.
REQ-016 SHALL have port out_ready, input, 1 bit: sink accepts the result.
REQ-017 SHALL have port out_bits, output, R*D bits: decoded word.
REQ-018 SHALL have port out_ok, output, 1 bit: converged.
REQ-019 SHALL have port out_tmo, output, 1 bit: controller timeout.
REQ-020 SHALL have port busy, output, 1 bit: state != IDLE.
REQ-021 SHALL have port frame_cnt, output, 16 bits: frames completed, saturating.
REQ-022 SHALL have port fail_cnt, output, 16 bits: frames with out_ok=0, saturating.

Function
REQ-023 SHALL implement FSM states IDLE, LOAD, RUN and DONE; all outputs registered.
REQ-024 SHALL, in IDLE, drive in_ready=1, core_rst=1 and core_en=0.
REQ-025 SHALL, on in_valid&in_ready, capture in_llr into core_l, drop in_ready, and enter LOAD.
REQ-026 SHALL hold core_rst=1 for exactly 2 LOAD cycles, then go to RUN with core_rst=0 and core_en=1.
REQ-027 SHALL keep core_l stable from capture until the next accepted frame.
REQ-028 SHALL, in RUN, increment a 10-bit cycle counter that is cleared on RUN entry.
REQ-029 SHALL ignore core_status in the first RUN cycle (guard cycle).
REQ-030 SHALL, when core_status[0]=1 after the guard cycle, latch out_bits=core_s and out_ok=1, set out_tmo=0, drop core_en, and enter DONE.
REQ-031 SHALL, when core_status[1]=1 without bit0, latch out_bits=core_s and set out_ok=0, out_tmo=0, then enter DONE.
REQ-032 SHALL give bit0 priority when both status bits are 1 in the same cycle.
REQ-033 SHALL, when the counter reaches MAX_CYC with no status, latch core_s and set out_ok=0, out_tmo=1, then enter DONE.
REQ-034 SHALL give status priority over timeout when both occur in the same cycle.
REQ-035 SHALL assert out_valid in the first DONE cycle and hold out_valid, out_bits, out_ok and out_tmo stable until out_ready.
REQ-036 SHALL, on out_valid&out_ready, clear out_valid, increment frame_cnt, increment fail_cnt if out_ok=0, and return to IDLE.
REQ-037 SHALL saturate frame_cnt and fail_cnt at 16'hFFFF with no wrap.
REQ-038 SHALL give a latency from in handshake (cycle 0) to the first RUN cycle of 3 cycles, and from status sampled to out_valid of 1 cycle.
REQ-039 SHALL keep in_ready=0 in LOAD, RUN and DONE, ignoring in_valid.

Reset
REQ-040 SHALL, while rst=0, immediately force state to IDLE, in_ready=0, core_rst=1, and core_en, out_valid, out_ok, out_tmo and busy to 0.
REQ-041 SHALL, while rst=0, clear out_bits, core_l, frame_cnt, fail_cnt and the cycle counter to 0.
REQ-042 SHALL set in_ready=1 on the first clock edge after rst rises.
REQ-043 SHALL, on reset mid-frame (any state), discard the frame without producing a result and leave the counters at 0.

Verification
REQ-044 SHALL cover this case: a frame is accepted at cycle 0 and core_status=01 at RUN cycle 40 -> core_rst=1 in cycles 1-2, core_en=1 from cycle 3, then out_valid=1 with out_ok=1 and out_bits=core_s; frame_cnt=1 after out_ready.
REQ-045 SHALL cover this case: with MAX_CYC=200 and core_status held at 00 -> out_tmo=1, out_ok=0, and out_valid asserted 1 cycle after the counter reaches 200; fail_cnt=1.
REQ-046 SHALL cover this case: core_status=11 in a single cycle -> out_ok=1, out_tmo=0.
REQ-047 SHALL cover this case: out_ready held at 0 for 20 cycles in DONE -> outputs stable and in_ready=0 throughout, with one count increment on release.
REQ-048 SHALL cover this case: core_status=01 during the guard cycle -> ignored, and RUN continues.
REQ-049 SHALL cover this case: rst pulled low mid-RUN, then released -> core_rst=1, out_valid=0, counters=0, and in_ready=1 one edge after release.
